// File: rtl/count_capture_fifo.sv
// count_capture_fifo: snapshots a free-running counter with a wrap-count tag into a show-ahead FIFO
// drained through a valid/ready handshake.
module count_capture_fifo #(
  parameter int CNT_W  = 4,
  parameter int WRAP_W = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        count_in,
  input  logic                    capture,
  input  logic                    clear_ovf,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [WRAP_W+CNT_W-1:0] out_data,
  output logic                    full,
  output logic [ADDR_W:0]         level,
  output logic                    overflow
);
  logic [CNT_W-1:0]        r_prev;
  logic [WRAP_W-1:0]       r_wrap;
  logic [WRAP_W+CNT_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]       r_rd, r_wr;
  logic [ADDR_W:0]         r_level;
  logic                    r_ovf;
  logic                    w_wrap, w_push, w_pop;
  logic [WRAP_W-1:0]       w_tag;
  // A capture coinciding with a rollover must already carry the incremented tag.
  assign w_wrap    = (r_prev == '1) && (count_in == '0);
  assign w_tag     = r_wrap + WRAP_W'(w_wrap);
  assign out_valid = r_level != '0;
  assign full      = r_level == (ADDR_W+1)'(DEPTH);
  assign w_pop     = out_valid && out_ready;
  assign w_push    = capture && (!full || w_pop);
  assign out_data  = out_valid ? r_mem[r_rd] : '0;
  assign level     = r_level;
  assign overflow  = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= '0;
      r_wrap  <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_prev  <= count_in;
      r_wrap  <= w_tag;
      r_rd    <= w_pop ? r_rd + ADDR_W'(1) : r_rd;
      r_wr    <= w_push ? r_wr + ADDR_W'(1) : r_wr;
      r_level <= r_level + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
      r_ovf   <= (capture && !w_push) || (r_ovf && !clear_ovf);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {w_tag, count_in};
  end
endmodule

// File: tb/tb_count_capture_fifo.sv
// tb_count_capture_fifo: directed vectors with hand-computed expectations for count_capture_fifo.
module tb_count_capture_fifo;
  logic       clk = 1'b0;
  logic       rst, capture, clear_ovf, out_ready;
  logic [3:0] count_in;
  logic       out_valid, full, overflow;
  logic [7:0] out_data;
  logic [2:0] level;
  int n_cmp = 0;
  int n_bad = 0;

  count_capture_fifo dut (
    .clk(clk), .rst(rst), .count_in(count_in), .capture(capture), .clear_ovf(clear_ovf),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .full(full),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] c, input logic cap, input logic rdy, input logic clr, input logic r);
    count_in = c; capture = cap; out_ready = rdy; clear_ovf = clr; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic state(input string tag, input logic v, input logic [7:0] d, input logic [2:0] l,
                       input logic f, input logic o);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"}, 32'(out_data), 32'(d));
    check({tag, ".level"}, 32'(level), 32'(l));
    check({tag, ".full"}, 32'(full), 32'(f));
    check({tag, ".ovf"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    state("reset", 0, 8'h00, 0, 0, 0);
    // single capture, hold, then drain
    cyc(5, 1, 0, 0, 0);
    state("cap1", 1, 8'h05, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(5, 0, 0, 0, 0);
      check("hold", 32'(out_data), 32'h05);
    end
    cyc(5, 0, 1, 0, 0);
    state("pop1", 0, 8'h00, 0, 0, 0);
    // run 6..15, 0..15, 0..2 (two wraps), then capture at 3
    for (int k = 6; k < 35; k++) cyc(4'(k % 16), 0, 0, 0, 0);
    cyc(3, 1, 0, 0, 0);
    state("wrap2", 1, 8'h23, 1, 0, 0);
    cyc(4, 0, 1, 0, 0);
    check("wrap2.pop", 32'(level), 0);
    for (int k = 5; k < 16; k++) cyc(4'(k), 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    state("wrapcap", 1, 8'h30, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("wrapcap.pop", 32'(level), 0);
    // fill and overflow
    for (int k = 1; k < 5; k++) cyc(4'(k), 1, 0, 0, 0);
    state("full4", 1, 8'h31, 4, 1, 0);
    cyc(5, 1, 0, 0, 0);
    state("drop", 1, 8'h31, 4, 1, 1);
    cyc(6, 0, 0, 1, 0);
    state("clrovf", 1, 8'h31, 4, 1, 0);
    // full with simultaneous push and pop
    cyc(7, 1, 1, 0, 0);
    state("pushpop", 1, 8'h32, 4, 1, 0);
    cyc(8, 0, 1, 0, 0);
    state("drain1", 1, 8'h33, 3, 0, 0);
    cyc(8, 0, 1, 0, 0);
    state("drain2", 1, 8'h34, 2, 0, 0);
    cyc(8, 0, 1, 0, 0);
    state("drain3", 1, 8'h37, 1, 0, 0);
    cyc(8, 0, 1, 0, 0);
    state("drain4", 0, 8'h00, 0, 0, 0);
    // reset mid-drain
    cyc(9, 1, 0, 0, 0);
    cyc(10, 1, 0, 0, 0);
    cyc(11, 1, 0, 0, 0);
    check("mid.level", 32'(level), 3);
    cyc(11, 0, 1, 0, 0);
    state("mid.pop", 1, 8'h3a, 2, 0, 0);
    cyc(11, 0, 0, 0, 1);
    state("mid.rst", 0, 8'h00, 0, 0, 0);
    cyc(12, 1, 0, 0, 0);
    state("postrst", 1, 8'h0c, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
